multi_sigma_dac: RTL

- Multi-channel, mode-selectable 1-bit audio DAC modulator. Generation after the single-channel random-threshold DAC.
- Each channel can run as a dithered threshold, a first-order sigma-delta or a second-order sigma-delta, selected at run time.
- Adds a sample-load strobe, clock-enable, mute and a shared LFSR noise source.
- Sits between the audio mixer and the FPGA output pins; each q bit drives an external RC filter.

---
 rtl/multi_sigma_dac.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/multi_sigma_dac.sv
// Multi-channel 1-bit audio DAC modulator. Each channel runs a dithered
// threshold, a first-order or a second-order sigma-delta loop, selected at
// run time. One shared 32-bit LFSR supplies dither noise to every channel;
// each channel sees a differently rotated view of it.
module multi_sigma_dac #(
  parameter int          signalwidth = 16,
  parameter int          channels    = 2,
  parameter logic [31:0] seed        = 32'd123456789
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              ce,
  input  logic [1:0]                        mode,
  input  logic                              mute,
  input  logic [channels*signalwidth-1:0]   d,
  input  logic                              d_valid,
  output logic [channels-1:0]               q
);

  // Integrators carry 4 bits of headroom; intermediate sums get 2 more so
  // that adding the sample and subtracting feedback never overflows before
  // the clamp is applied.
  localparam int IW = signalwidth + 4;
  localparam int EW = signalwidth + 6;

  localparam logic [1:0] MODE_DITHER = 2'd0;
  localparam logic [1:0] MODE_SECOND = 2'd2;

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-IW+1){1'b1}}, {(IW-1){1'b0}}};

  // Clamp a wide signed sum into the integrator range instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[IW-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[IW-1:0];
    end else begin
      r = v[IW-1:0];
    end
    return r;
  endfunction

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [1:0]  mode_r_q;
  logic        clear;

  // A mode switch or mute wipes every channel's loop state on this edge.
  assign clear = mute | (mode != mode_r_q);

  // Fibonacci LFSR, taps 32,22,2,1 (maximal length).
  always_comb begin
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  // Noise source advances only on enabled cycles, independent of mute.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= seed;
    end else if (ce) begin
      lfsr_q <= lfsr_d;
    end
  end

  // Mode is sampled every edge so a change can be detected against it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r_q <= MODE_DITHER;
    end else begin
      mode_r_q <= mode;
    end
  end

  for (genvar gi = 0; gi < channels; gi++) begin : g_ch
    localparam int ROT = (7 * gi) % 32;

    logic [signalwidth-1:0]   hold_q;
    logic [signalwidth-1:0]   acc_q;
    logic [signalwidth-1:0]   acc_d;
    logic signed [IW-1:0]     i1_q;
    logic signed [IW-1:0]     i1_d;
    logic signed [IW-1:0]     i2_q;
    logic signed [IW-1:0]     i2_d;
    logic signed [IW-1:0]     i1_sat;
    logic signed [IW-1:0]     i2_sat;
    logic                     q_q;
    logic                     q_d;
    logic [signalwidth-1:0]   noise;
    logic                     dither_bit;
    logic [signalwidth:0]     fsum;
    logic signed [EW-1:0]     hold_ext;
    logic signed [EW-1:0]     fb_ext;
    logic signed [EW-1:0]     i1_sum;
    logic signed [EW-1:0]     i2_sum;

    // Channel noise is the LFSR rotated left by 7*gi bits, low bits taken.
    for (genvar gj = 0; gj < signalwidth; gj++) begin : g_noise
      assign noise[gj] = lfsr_q[(gj + 32 - ROT) % 32];
    end

    // noise + hold carries out exactly when noise exceeds the bitwise
    // complement of hold, so the carry is taken without a full adder output.
    assign dither_bit = (noise > ~hold_q);

    assign fsum     = {1'b0, acc_q} + {1'b0, hold_q};
    assign hold_ext = {{(EW-signalwidth){1'b0}}, hold_q};
    assign fb_ext   = {{(EW-signalwidth-1){1'b0}}, q_q, {signalwidth{1'b0}}};
    assign i1_sum   = {{(EW-IW){i1_q[IW-1]}}, i1_q} + hold_ext - fb_ext;
    assign i1_sat   = sat(i1_sum);
    assign i2_sum   = {{(EW-IW){i2_q[IW-1]}}, i2_q} + {{(EW-IW){i1_sat[IW-1]}}, i1_sat} - fb_ext;
    assign i2_sat   = sat(i2_sum);

    // Next-state selection for this channel's modulator.
    always_comb begin
      q_d   = q_q;
      acc_d = acc_q;
      i1_d  = i1_q;
      i2_d  = i2_q;
      if (clear) begin
        q_d   = 1'b0;
        acc_d = '0;
        i1_d  = '0;
        i2_d  = '0;
      end else if (ce) begin
        case (mode_r_q)
          MODE_DITHER: begin
            q_d = dither_bit;
          end
          MODE_SECOND: begin
            q_d  = !i2_sat[IW-1] && (i2_sat != '0);
            i1_d = i1_sat;
            i2_d = i2_sat;
          end
          default: begin
            q_d   = fsum[signalwidth];
            acc_d = fsum[signalwidth-1:0];
          end
        endcase
      end
    end

    // Sample hold register loads on the strobe regardless of ce.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
      end else if (d_valid) begin
        hold_q <= d[gi*signalwidth +: signalwidth];
      end
    end

    // Modulator state and registered output bit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q_q   <= 1'b0;
        acc_q <= '0;
        i1_q  <= '0;
        i2_q  <= '0;
      end else begin
        q_q   <= q_d;
        acc_q <= acc_d;
        i1_q  <= i1_d;
        i2_q  <= i2_d;
      end
    end

    assign q[gi] = q_q;
  end

endmodule
